// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV and DIVU.
// Operations are accepted in IDLE, iterate WIDTH cycles in RUN, and
// sign-correct and commit to the architectural HI/LO registers in FIX.
// HI/LO also serve MTHI/MTLO writes while the unit is idle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  // op[1] selects divide, op[0] selects the unsigned variant.
  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t             state_q;
  logic               is_div_q;
  logic               neg_q;        // product or quotient must be negated
  logic               rem_neg_q;    // remainder must be negated
  logic               dbz_q;        // divide with a zero divisor
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   opa_q;        // |a|; becomes the quotient while dividing
  logic [WIDTH-1:0]   opb_q;        // |b|; shifts out multiplier bits
  logic [WIDTH-1:0]   raw_a_q;      // unmodified dividend for divide-by-zero
  logic [2*WIDTH-1:0] acc_q;        // product accumulator
  logic [WIDTH-1:0]   rem_q;        // partial remainder
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               div_by_zero_q;

  // Operand conditioning, one RUN iteration, and FIX sign correction.
  logic               req_signed;
  logic               req_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   opa_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    req_signed = (op_t'(op) == OP_MULT) || (op_t'(op) == OP_DIV);
    req_div    = op[1];
    a_neg      = req_signed && a[WIDTH-1];
    b_neg      = req_signed && b[WIDTH-1];
    mag_a      = a_neg ? -a : a;
    mag_b      = b_neg ? -b : b;

    // Multiply: add |a| into the upper half when the current multiplier
    // bit is set, then shift the whole accumulator right by one.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (opb_q[0] ? opa_q : '0)};
    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: the shifted partial remainder is WIDTH+1 bits so a dividend
    // magnitude of 2^(WIDTH-1) cannot overflow. When it is >= the divisor
    // the difference always fits back into WIDTH bits.
    div_shift = {rem_q, opa_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    rem_d     = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
    opa_d     = {opa_q[WIDTH-2:0], div_ge};

    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -opa_q : opa_q;
    rem_fix  = rem_neg_q ? -rem_q : rem_q;
  end

  // Control FSM, datapath registers, HI/LO and the registered status outputs.
  // NOTE: every register in this block uses non-blocking assignment so all
  // of them update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q       <= S_IDLE;
      is_div_q      <= 1'b0;
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
      dbz_q         <= 1'b0;
      cnt_q         <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      raw_a_q       <= '0;
      acc_q         <= '0;
      rem_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            is_div_q  <= req_div;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dbz_q     <= req_div && (b == '0);
            opa_q     <= mag_a;
            opb_q     <= mag_b;
            raw_a_q   <= a;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            state_q   <= S_RUN;
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        S_RUN: begin
          if (is_div_q) begin
            rem_q <= rem_d;
            opa_q <= opa_d;
          end else begin
            acc_q <= acc_d;
            opb_q <= opb_q >> 1;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_q <= S_FIX;
        end
        S_FIX: begin
          if (!is_div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (dbz_q) begin
            hi_q <= raw_a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q        <= 1'b1;
          div_by_zero_q <= is_div_q && dbz_q;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push their
// hand-computed HI/LO/flag results into a queue, and a monitor pops and
// compares every time the unit pulses done.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;
  int   busy_n   = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_b === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"},  64'(hi), 64'(e.hi));
        check({e.name, "_lo"},  64'(lo), 64'(e.lo));
        check({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
        check({e.name, "_busy_with_done"}, 64'(busy), 64'd0);
      end
    end
  end

  // Advance one edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    if (busy) busy_n++;
  endtask

  task automatic accept(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    op     = 2'd0;
    edge_n = 0;
    busy_n = busy ? 1 : 0;
  endtask

  task automatic wait_done(input string name);
    while (done !== 1'b1 && edge_n < 40) step();
    check({name, "_latency"}, 64'(edge_n), 64'd33);
    check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                        input string name);
    exp_t e;
    e.hi = eh; e.lo = el; e.dbz = ed; e.name = name;
    sb.push_back(e);
    accept(o, aa, bb);
    wait_done(name);
  endtask

  task automatic move_to(input logic wh, input logic wl, input logic [W-1:0] d);
    @(negedge clk);
    mthi  = wh;
    mtlo  = wl;
    wdata = d;
    @(posedge clk);
    #1;
    mthi  = 1'b0;
    mtlo  = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz",  64'(div_by_zero), 64'd0);
    check("reset_hi",   64'(hi), 64'd0);
    check("reset_lo",   64'(lo), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // 12 * -34 = -408
    run_op(2'd0, 32'd12, 32'hFFFF_FFDE, 32'hFFFF_FFFF, 32'hFFFF_FE68, 1'b0, "mult_12_m34");
    // (2^32-1)^2 unsigned, then the same bits as signed -1 * -1, back-to-back
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, "mult_m1_m1");
    // -7 / 2 = -3 rem -1 ; 7 / -2 = -3 rem 1
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7_m2");
    // most negative / -1
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_min_m1");
    // 100 / 7 = 14 rem 2 ; 100 / 0 flags
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7");
    run_op(2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, "divu_by_zero");

    // A start and an MTHI in the middle of a MULT must both be dropped.
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd42; e.dbz = 1'b0; e.name = "mult_ignored_inputs";
      sb.push_back(e);
      accept(2'd0, 32'd7, 32'd6);
      repeat (4) step();
      @(negedge clk);
      start = 1'b1;
      op    = 2'd3;
      a     = 32'd1;
      b     = 32'd1;
      mthi  = 1'b1;
      wdata = 32'h1234;
      step();
      start = 1'b0;
      mthi  = 1'b0;
      check("hi_hold_during_run", 64'(hi), 64'd100);
      check("lo_hold_during_run", 64'(lo), 64'hFFFF_FFFF);
      wait_done("mult_ignored_inputs");
    end

    // Both moves in one cycle.
    move_to(1'b1, 1'b1, 32'hABCD_0001);
    check("mthi_mtlo_hi", 64'(hi), 64'hABCD_0001);
    check("mthi_mtlo_lo", 64'(lo), 64'hABCD_0001);

    // Reset in the middle of a DIV aborts it with no done.
    accept(2'd2, 32'd1000, 32'd7);
    repeat (9) step();
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi",   64'(hi), 64'd0);
    check("abort_lo",   64'(lo), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_still_idle", 64'(busy), 64'd0);

    move_to(1'b0, 1'b1, 32'h55);
    check("mtlo_lo", 64'(lo), 64'h55);
    check("mtlo_hi_untouched", 64'(hi), 64'd0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit that executes the HI/LO-class MIPS operations (MULT, MULTU, DIV, DIVU) over multiple cycles. The single-cycle ALU handles all other operations; the decode/control stage issues these here and stalls on `busy`. Results land in the architectural HI/LO registers held inside this block, which also serve MTHI/MTLO and MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock, rising edge
- `rst_b`  in  1  synchronous, active-low reset
- `start`  in  1  request strobe, sampled only when `busy`=0
- `op`  in  2  operation: 0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU
- `a`  in  WIDTH  multiplicand or dividend (rs)
- `b`  in  WIDTH  multiplier or divisor (rt)
- `mthi`  in  1  write `wdata` to HI
- `mtlo`  in  1  write `wdata` to LO
- `wdata`  in  WIDTH  MTHI/MTLO data
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse when HI/LO are updated by an operation
- `div_by_zero`  out  1  asserted with `done` when a DIV or DIVU had `b`=0
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1:
  - Latch `op`.
  - Signed ops: latch operand magnitudes and record the result sign. MULT sign is sign(a) XOR sign(b). For DIV, the quotient sign is sign(a) XOR sign(b) and the remainder sign is sign(a).
  - Clear the 2·WIDTH accumulator and the iteration counter, then go to RUN.
- RUN: one iteration per cycle for WIDTH cycles, then go to FIX.
  - Multiply: radix-2 shift-add on magnitudes, LSB first, into a 2·WIDTH accumulator.
  - Divide: restoring, MSB first. The remainder is WIDTH+1 bits wide, so there is no overflow on |a|=2^31.
- FIX:
  - Apply sign correction by two's-complement negation of the product, quotient or remainder as recorded.
  - MULT/MULTU: `hi`=product[2W-1:W], `lo`=product[W-1:0].
  - DIV/DIVU: `lo`=quotient, `hi`=remainder. Division truncates toward zero.
  - Assert `done` for one cycle and return to IDLE.
- Divide by zero: the operation still takes the full latency. Result is `lo`=all ones and `hi`=`a` (raw dividend, unsigned view), with `div_by_zero`=1 alongside `done`.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. There is no flag.
- `mthi`/`mtlo` in IDLE with `start`=0 write the register at the next edge. Both may be asserted together.
- Ignored inputs:
  - `start` with `busy`=1 (no queuing).
  - `mthi`/`mtlo` with `busy`=1.
  - `mthi`/`mtlo` in the same cycle as an accepted `start` (start wins).
- `a`, `b` and `op` are don't-care after the accepting edge.

## Timing
- Reset (`rst_b`=0 at an edge):
  - State goes to IDLE.
  - `busy`, `done`, `div_by_zero` go to 0.
  - `hi`, `lo` go to 0.
  - Any in-flight operation is aborted silently, with no `done`.
- Accept edge E0 (IDLE, `start`=1): `busy`=1 from E0.
- RUN iterations occur at edges E1..E32.
- FIX at E33:
  - `hi`/`lo` update.
  - `done`=1 and `div_by_zero` are valid.
  - `busy`=0, all for exactly the cycle after E33.
- Latency is 33 edges from accept to result. `done` and `busy` are never high together.
- A new `start` is accepted at E33's following edge (back-to-back). The issue interval is 34 cycles.
- `hi`/`lo` hold their old values throughout RUN/FIX until E33.
- `done` and `div_by_zero` are registered outputs. `busy` is decoded from state.

## Test plan
- MULT a=12, b=0xFFFFFFDE (−34) → `done` 33 edges after accept. `hi`=0xFFFFFFFF, `lo`=0xFFFFFE68; `busy` high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. Then, back-to-back, MULT with the same operands → `hi`=0, `lo`=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_by_zero`=0.
- DIVU a=100, b=0 → `div_by_zero`=1 with `done`; `lo`=0xFFFFFFFF, `hi`=100.
- Ignored inputs and reset:
  - `start` and `mthi` (wdata=0x1234) issued at cycle 5 of a MULT → both ignored, and the MULT result is intact.
  - `rst_b`=0 at cycle 10 of a DIV → no `done`, `hi`=`lo`=0, `busy`=0.
  - Subsequent MTLO 0x55 → `lo`=0x55 next cycle.
